// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver: FSM state codes, direction codes,
// grid bounds and the neighbour-step helper.
package maze_pkg;

  localparam logic [3:0] GRID_MAX = 4'd15;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHKSTART = 3'd1;
  localparam logic [2:0] ST_MARK     = 3'd2;
  localparam logic [2:0] ST_TRY      = 3'd3;
  localparam logic [2:0] ST_BACK     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_FAIL     = 3'd6;

  // Direction codes, tried in ascending order. The opposite of a direction
  // is its bitwise inverse (0<->3, 1<->2).
  localparam logic [1:0] DIR_YP = 2'd0;
  localparam logic [1:0] DIR_XP = 2'd1;
  localparam logic [1:0] DIR_XM = 2'd2;
  localparam logic [1:0] DIR_YM = 2'd3;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;

  typedef struct packed {
    logic   off_grid;
    coord_t pos;
  } step_t;

  // One step from c in direction dir; off_grid flags a move that would wrap.
  function automatic step_t step_coord(input coord_t c, input logic [1:0] dir);
    step_t s;
    s.off_grid = 1'b0;
    s.pos      = c;
    case (dir)
      DIR_YP: begin
        s.off_grid = (c.y == GRID_MAX);
        s.pos.y    = c.y + 4'd1;
      end
      DIR_XP: begin
        s.off_grid = (c.x == GRID_MAX);
        s.pos.x    = c.x + 4'd1;
      end
      DIR_XM: begin
        s.off_grid = (c.x == 4'd0);
        s.pos.x    = c.x - 4'd1;
      end
      default: begin
        s.off_grid = (c.y == 4'd0);
        s.pos.y    = c.y - 4'd1;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/maze_solver_ctrl_if.sv
// Bundle of the solver's control and maze-memory signals.
// Strobe semantics: read=1 means X,Y address a cell and mode must hold that
// cell's value combinationally in the same cycle; write=1 means the cell at
// X,Y takes d_in at the next rising edge. read and write are never both 1.
interface maze_solver_ctrl_if;
  logic       start;
  logic       mode;
  logic [3:0] X;
  logic [3:0] Y;
  logic       read;
  logic       write;
  logic       d_in;
  logic       done;
  logic       fail;
  logic [8:0] path_len;

  modport master (
    input  start, mode,
    output X, Y, read, write, d_in, done, fail, path_len
  );

  modport slave (
    output start, mode,
    input  X, Y, read, write, d_in, done, fail, path_len
  );
endinterface

// File: rtl/maze_dir_stack.sv
// LIFO of 2-bit move directions, 256 deep. top is the most recent push and
// is only meaningful while empty=0.
module maze_dir_stack (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_clear,
  input  logic [1:0] i_data,
  output logic [1:0] o_top,
  output logic [8:0] o_count,
  output logic       o_empty
);

  logic [1:0] r_mem [0:255];
  logic [8:0] r_count;
  logic [7:0] w_top_idx;

  // Entry count: clear/reset empty the stack, push and pop step it.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= 9'd0;
    end else if (i_push) begin
      r_count <= r_count + 9'd1;
    end else if (i_pop) begin
      r_count <= r_count - 9'd1;
    end
  end

  // Storage array: contents need no reset, the count defines what is valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_count[7:0]] <= i_data;
    end
  end

  assign w_top_idx = r_count[7:0] - 8'd1;
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;
  assign o_empty   = (r_count == 9'd0);

endmodule

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver: walks a 16x16 grid from start to goal, marking
// visited cells in external memory and backtracking via a direction stack.
module maze_solver_ctrl
  import maze_pkg::*;
#(
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  maze_solver_ctrl_if.master   bus,
  output logic [2:0]           o_dbg_state
);

  localparam coord_t START_POS = {4'(START_X), 4'(START_Y)};
  localparam coord_t GOAL_POS  = {4'(GOAL_X), 4'(GOAL_Y)};

  logic [2:0] r_state;
  coord_t     r_cur;
  logic [1:0] r_dir;

  step_t      w_nb;
  step_t      w_back;
  logic       w_push;
  logic       w_pop;
  logic       w_clear;
  logic [1:0] w_top;
  logic [8:0] w_count;
  logic       w_empty;

  // Candidate neighbour for TRY, and the cell we came from for BACK
  // (stepping in the inverse of the popped direction).
  assign w_nb   = step_coord(r_cur, r_dir);
  assign w_back = step_coord(r_cur, ~w_top);

  maze_dir_stack u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (r_dir),
    .o_top   (w_top),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Memory strobes, address mux and stack controls decoded from the state.
  always_comb begin
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.X     = r_cur.x;
    bus.Y     = r_cur.y;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      ST_IDLE:     w_clear = bus.start;
      ST_CHKSTART: bus.read = 1'b1;
      ST_MARK:     bus.write = 1'b1;
      ST_TRY: begin
        if (!w_nb.off_grid) begin
          bus.read = 1'b1;
          bus.X    = w_nb.pos.x;
          bus.Y    = w_nb.pos.y;
          w_push   = !bus.mode;
        end
      end
      ST_BACK:     w_pop = !w_empty;
      default: ;
    endcase
  end

  // Search FSM: current cell, direction under test and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_dir   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_cur   <= START_POS;
            r_dir   <= 2'd0;
            r_state <= ST_CHKSTART;
          end
        end
        ST_CHKSTART: begin
          r_state <= bus.mode ? ST_FAIL : ST_MARK;
        end
        ST_MARK: begin
          if (r_cur == GOAL_POS) begin
            r_state <= ST_DONE;
          end else begin
            r_dir   <= 2'd0;
            r_state <= ST_TRY;
          end
        end
        ST_TRY: begin
          if (!w_nb.off_grid && !bus.mode) begin
            r_cur   <= w_nb.pos;
            r_state <= ST_MARK;
          end else if (r_dir != DIR_YM) begin
            r_dir <= r_dir + 2'd1;
          end else begin
            r_state <= ST_BACK;
          end
        end
        ST_BACK: begin
          if (w_empty) begin
            r_state <= ST_FAIL;
          end else begin
            r_cur <= w_back.pos;
            if (w_top != DIR_YM) begin
              r_dir   <= w_top + 2'd1;
              r_state <= ST_TRY;
            end
          end
        end
        ST_DONE: r_state <= ST_DONE;
        ST_FAIL: r_state <= ST_FAIL;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.d_in     = 1'b1;
  assign bus.done     = (r_state == ST_DONE);
  assign bus.fail     = (r_state == ST_FAIL);
  assign bus.path_len = w_count;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Bench for maze_solver_ctrl: maze memory model, trace-generating DFS model,
// per-cycle output compare and directed maze scenarios.
module tb_maze_solver_ctrl;
  import maze_pkg::*;

  localparam int SX = 0;
  localparam int SY = 0;
  localparam int GX = 15;
  localparam int GY = 15;
  localparam int W  = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_solver_ctrl_if bus ();
  logic [2:0] dbg_state;

  maze_solver_ctrl #(.START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- maze memory ----------------
  bit   maze_mem [16][16];
  logic r_junk = 1'b0;

  always @(negedge clk) r_junk = 1'($urandom_range(0, 1));
  assign bus.mode = bus.read ? maze_mem[bus.X][bus.Y] : r_junk;
  always @(posedge clk) if (bus.write) maze_mem[bus.X][bus.Y] = 1'b1;

  task automatic clear_maze();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) maze_mem[x][y] = 1'b0;
  endtask

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int trace_idx, cyc, n_writes, first_fail, back_run, first_back_run;
  logic [2:0] after_back_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dx(input int d);
    return (d == 1) ? 1 : (d == 2) ? -1 : 0;
  endfunction
  function automatic int dy(input int d);
    return (d == 0) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  task automatic push_exp(input int x, input int y, input bit r, input bit w,
                          input int len, input bit d, input bit f);
    exp_q.push_back({4'(x), 4'(y), r, w, 1'b1, 9'(len), d, f});
  endtask

  task automatic push_term(input int x, input int y, input int len, input bit d, input bit f);
    repeat (3) push_exp(x, y, 1'b0, 1'b0, len, d, f);
  endtask

  // Expected per-cycle outputs of a depth-first search over a copy of the maze:
  // one entry per check, mark, probe and backtrack step, then the end state.
  task automatic build_trace();
    bit m [16][16];
    int stk[$];
    int cx, cy, d, nx, ny, p;
    bit moved;
    m = maze_mem;
    exp_q.delete();
    cx = SX; cy = SY;
    push_exp(cx, cy, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    if (m[cx][cy]) begin
      push_term(cx, cy, 0, 1'b0, 1'b1);
      return;
    end
    forever begin
      push_exp(cx, cy, 1'b0, 1'b1, stk.size(), 1'b0, 1'b0);
      m[cx][cy] = 1'b1;
      if (cx == GX && cy == GY) begin
        push_term(cx, cy, stk.size(), 1'b1, 1'b0);
        return;
      end
      d = 0;
      moved = 1'b0;
      while (!moved) begin
        while (d < 4 && !moved) begin
          nx = cx + dx(d);
          ny = cy + dy(d);
          if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
            push_exp(cx, cy, 1'b0, 1'b0, stk.size(), 1'b0, 1'b0);
            d++;
          end else begin
            push_exp(nx, ny, 1'b1, 1'b0, stk.size(), 1'b0, 1'b0);
            if (!m[nx][ny]) begin
              stk.push_back(d);
              cx = nx; cy = ny;
              moved = 1'b1;
            end else begin
              d++;
            end
          end
        end
        if (!moved) begin
          forever begin
            push_exp(cx, cy, 1'b0, 1'b0, stk.size(), 1'b0, 1'b0);
            if (stk.size() == 0) begin
              push_term(cx, cy, 0, 1'b0, 1'b1);
              return;
            end
            p = stk.pop_back();
            cx -= dx(p);
            cy -= dy(p);
            if (p != 3) begin
              d = p + 1;
              break;
            end
          end
        end
      end
    end
  endtask

  // ---------------- compare / monitor process ----------------
  always @(posedge clk) begin
    logic [W-1:0] e, a;
    #1;
    if (chk_en) begin
      cyc++;
      if (bus.write) n_writes++;
      if (bus.fail && first_fail < 0) first_fail = cyc;
      if (dbg_state == ST_BACK) begin
        back_run++;
      end else begin
        if (back_run > 0 && first_back_run < 0) begin
          first_back_run   = back_run;
          after_back_state = dbg_state;
        end
        back_run = 0;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.X, bus.Y, bus.read, bus.write, bus.d_in, bus.path_len, bus.done, bus.fail};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL trace[%0d] X,Y,rd,wr,din,len,done,fail got %0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
                   trace_idx, a[21:18], a[17:14], a[13], a[12], a[11], a[10:2], a[1], a[0],
                   e[21:18], e[17:14], e[13], e[12], e[11], e[10:2], e[1], e[0]);
        end
        trace_idx++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a search against the already-built trace. abort_at>0 asserts rst
  // after that many cycles instead of running to the end.
  task automatic run_search(input int abort_at);
    int budget;
    budget = exp_q.size() + 20;
    @(negedge clk);
    trace_idx = 0; cyc = 0; n_writes = 0; first_fail = -1;
    back_run = 0; first_back_run = -1; after_back_state = ST_IDLE;
    bus.start = 1'b1;
    chk_en    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < budget; i++) begin
      if (abort_at > 0 && i == abort_at) begin
        rst    = 1'b1;
        chk_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("reset_mid_outputs",
              {bus.X, bus.Y, bus.read, bus.write, bus.path_len, bus.done, bus.fail}, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL search_timeout: %0d trace entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int bad_cells;
    bus.start = 1'b0;
    clear_maze();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_outputs",
          {bus.X, bus.Y, bus.read, bus.write, bus.path_len, bus.done, bus.fail}, 0);
    check("reset_state", dbg_state, ST_IDLE);

    // All-open map: 15 up then 15 right
    build_trace();
    check("model_open_len", exp_q.size(), 80);
    check("model_open_path", exp_q[exp_q.size()-1][10:2], 30);
    run_search(0);
    check("open_done", bus.done, 1);
    check("open_fail", bus.fail, 0);
    check("open_path_len", bus.path_len, 30);

    // Start cell is a wall
    apply_reset();
    clear_maze();
    maze_mem[0][0] = 1'b1;
    build_trace();
    check("model_wall_len", exp_q.size(), 4);
    run_search(0);
    check("wall_fail", bus.fail, 1);
    check("wall_fail_cycle", first_fail, 2);
    check("wall_no_write", n_writes, 0);

    // Goal fully enclosed: exhaustive search then fail
    apply_reset();
    clear_maze();
    maze_mem[14][15] = 1'b1;
    maze_mem[15][14] = 1'b1;
    build_trace();
    run_search(0);
    check("enclosed_fail", bus.fail, 1);
    check("enclosed_done", bus.done, 0);
    check("enclosed_path_len", bus.path_len, 0);
    bad_cells = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if (maze_mem[x][y] != ((x == 15 && y == 15) ? 1'b0 : 1'b1)) bad_cells++;
    check("enclosed_cells_marked", bad_cells, 0);

    // Dead-end corridor down column 1 forces five consecutive backtracks
    apply_reset();
    clear_maze();
    maze_mem[2][15] = 1'b1;
    maze_mem[2][14] = 1'b1;
    maze_mem[2][13] = 1'b1;
    maze_mem[2][12] = 1'b1;
    maze_mem[2][11] = 1'b1;
    maze_mem[1][10] = 1'b1;
    build_trace();
    run_search(0);
    check("corridor_back_run", first_back_run, 5);
    check("corridor_resume_try", after_back_state, ST_TRY);
    check("corridor_done", bus.done, 1);
    check("corridor_path_len", bus.path_len, 30);

    // Reset at cycle 20 of a search, then a clean rerun
    apply_reset();
    clear_maze();
    build_trace();
    run_search(20);
    clear_maze();
    build_trace();
    run_search(0);
    check("rerun_done", bus.done, 1);
    check("rerun_path_len", bus.path_len, 30);

    // start ignored once finished
    @(negedge clk);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    check("done_sticky", {bus.done, bus.read, bus.write}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_solver_ctrl.md
MAZE_SOLVER_CTRL -- requirements
Module: maze_solver_ctrl

Interface
REQ-001 Parameter START_X, default 0: start column.
REQ-002 Parameter START_Y, default 0: start row.
REQ-003 Parameter GOAL_X, default 15: goal column.
REQ-004 Parameter GOAL_Y, default 15: goal row.
REQ-005 Port clk  input  1: single clock, all state changes on rising edge.
REQ-006 Port rst  input  1: reset, synchronous, active-high.
REQ-007 Port start  input  1: begin search; level, sampled in IDLE only.
REQ-008 Port mode  input  1: maze cell value from memory; 0 = open, 1 = wall or visited; valid combinationally while read=1.
REQ-009 Port X, Y  output  4 each: cell address driven to maze memory.
REQ-010 Port read  output  1: memory read enable.
REQ-011 Port write  output  1: memory write enable, takes effect at the next clk edge.
REQ-012 Port d_in  output  1: write data, constant 1 (mark visited).
REQ-013 Port done  output  1: goal reached, sticky.
REQ-014 Port fail  output  1: no path exists, sticky.
REQ-015 Port path_len  output  9: number of moves currently on the path stack.

Function
REQ-016 FSM states SHALL be IDLE, CHKSTART, MARK, TRY, BACK, DONE, FAIL.
REQ-017 IDLE: read=write=0; start=1 -> cur=(START_X,START_Y), dir=0, stack cleared, go CHKSTART.
REQ-018 CHKSTART: X,Y=cur, read=1; mode=1 -> FAIL, else -> MARK.
REQ-019 MARK: X,Y=cur, write=1, d_in=1; cur==(GOAL_X,GOAL_Y) -> DONE, else dir=0 -> TRY.
REQ-020 Direction encoding: 0 = Y+1, 1 = X+1, 2 = X-1, 3 = Y-1; tried in ascending order.
REQ-021 TRY: neighbour of cur in dir computed in 4 bits; neighbour off-grid (wrap would occur) -> treated as wall, read=0, no wrap-around permitted.
REQ-022 TRY in-grid: X,Y=neighbour, read=1, mode sampled same edge; mode=0 -> push dir, cur=neighbour, -> MARK.
REQ-023 TRY wall/off-grid: dir<3 -> dir+1, stay TRY; dir==3 -> BACK.
REQ-024 BACK: stack empty -> FAIL; else pop p, cur = cur stepped in opposite of p, then p==3 -> stay BACK, else dir=p+1 -> TRY.
REQ-025 Latency: each TRY, MARK, BACK, CHKSTART occupies exactly one cycle; read and write never both 1 in the same cycle.
REQ-026 Stack depth 256 entries x 2 bits; path_len = entry count; push on full cannot occur (at most 255 moves on 256 cells) and needs no handling.
REQ-027 DONE: done=1, read=write=0, path_len holds final path length; stays until rst.
REQ-028 FAIL: fail=1, read=write=0; stays until rst; start ignored in DONE/FAIL.
REQ-029 Outside read/write cycles X,Y SHALL hold cur; mode is ignored whenever read=0 (memory drives z).

Reset
REQ-030 rst=1 at any edge, including mid-search, -> IDLE, done=fail=0, read=write=0, path_len=0, X=Y=0, dir=0, stack pointer 0.
REQ-031 Maze memory contents are restored by its own reset; rst SHALL be applied to both together before a new search.

Structure
REQ-032 Shared package maze_pkg: state encoding, direction codes, GRID_MAX=15.
REQ-033 One sub-module: maze_dir_stack (push, pop, clear, top, count, empty; synchronous, rst synchronous active-high).

Verification
REQ-034 All-open 16x16 map, start -> path_len=30 (15 up moves then 15 right), done=1, fail=0.
REQ-035 Start cell wall -> fail=1 two cycles after start, no write ever asserted.
REQ-036 Goal fully enclosed by walls -> fail=1, path_len=0, every reachable cell written to 1.
REQ-037 Single-corridor dead end forcing backtrack of 5 cells -> BACK entered 5 times consecutively, then TRY resumes with next direction, done=1.
REQ-038 rst asserted mid-search (cycle 20) -> next cycle all outputs at reset values; restarted search completes identically to clean run.
REQ-039 Edge cells: cur at X=15 trying dir 1 and Y=0 trying dir 3 -> read=0 that cycle, no wrap to 0/15.
